// File: rtl/counter16_cmos_pkg.sv
// counter16_cmos_pkg
//   Shared constants for the CMOS-track counter stage. The default counter
//   width and the reset/load encodings live here, so the top, the cells and
//   the bench all agree on them.
`ifndef COUNTER16_CMOS_PKG_SV
`define COUNTER16_CMOS_PKG_SV
package counter16_cmos_pkg;
  localparam int   WIDTH_DEF  = 16;
  localparam logic RST_ACTIVE = 1'b0;  // rst_n level that clears state
  localparam logic ST_LOAD    = 1'b1;  // st level that loads x
endpackage
`endif

// File: rtl/counter16_cmos_if.sv
// counter16_cmos_if
//   Bundles the counter's load/count controls and its outputs.
//   master : drives st, x, en; observes o, wrap
//   slave  : the counter; observes st, x, en; drives o, wrap
interface counter16_cmos_if #(parameter int WIDTH = 16);
  logic             st;
  logic [WIDTH-1:0] x;
  logic             en;
  logic [WIDTH-1:0] o;
  logic             wrap;

  modport master (output st, x, en, input  o, wrap);
  modport slave  (input  st, x, en, output o, wrap);
endinterface

// File: rtl/counter16_cmos_dff.sv
// Gate-level cells for the CMOS-track counter.
//   nand_cmos : 2-input NAND primitive (a_i, b_i -> y_o)
//   mux2_cmos : 2:1 mux from four NANDs; y_o = s_i ? a_i : b_i
//   dff_cmos  : 1-bit rising-edge flop with synchronous active-low reset
//               (clk_i, rst_ni, d_i -> q_o)
module nand_cmos (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

module mux2_cmos (
  input  logic s_i,
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic s_n, t_a, t_b;
  nand_cmos u_inv (.a_i(s_i), .b_i(s_i), .y_o(s_n));
  nand_cmos u_na  (.a_i(a_i), .b_i(s_i), .y_o(t_a));
  nand_cmos u_nb  (.a_i(b_i), .b_i(s_n), .y_o(t_b));
  nand_cmos u_out (.a_i(t_a), .b_i(t_b), .y_o(y_o));
endmodule

module dff_cmos (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic t_n, d_g, q_q, q_d;

  // Reset gate on D: d_g = d_i & rst_ni. Because it sits in front of the
  // storage element, reset only takes effect at a rising edge.
  nand_cmos u_rg0 (.a_i(d_i), .b_i(rst_ni), .y_o(t_n));
  nand_cmos u_rg1 (.a_i(t_n), .b_i(t_n),    .y_o(d_g));

  assign q_d = d_g;

  // Edge-triggered storage standing in for the NAND master/slave latch pair.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/counter16_cmos.sv
// counter16_cmos
//   WIDTH-bit registered counter with a synchronous load, a count enable and
//   a one-cycle wrap pulse. The datapath is built entirely from NAND cells.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous reset, active low (o=0, wrap=0)
//     bus   : slave side of counter16_cmos_if (st, x, en in; o, wrap out)
//   Edge priority: reset > load (st) > increment (en) > hold.
module counter16_cmos
  import counter16_cmos_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic             clk,
  input logic             rst_n,
  counter16_cmos_if.slave bus
);
  logic [WIDTH-1:0] o_q, o_d, sum, cnt_d;
  logic [WIDTH:0]   c;
  logic             wrap_q, wrap_d;
  logic             st_n, g_en, en_cnt, g_wr;

  // Incrementer: ripple half-adder chain with carry-in 1 at bit 0.
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic n1, n2, n3, na;
    // sum = o ^ c (4 NANDs)
    nand_cmos u_x1 (.a_i(o_q[i]), .b_i(c[i]), .y_o(n1));
    nand_cmos u_x2 (.a_i(o_q[i]), .b_i(n1),   .y_o(n2));
    nand_cmos u_x3 (.a_i(c[i]),   .b_i(n1),   .y_o(n3));
    nand_cmos u_x4 (.a_i(n2),     .b_i(n3),   .y_o(sum[i]));
    // carry = o & c (2 NANDs)
    nand_cmos u_a1 (.a_i(o_q[i]), .b_i(c[i]), .y_o(na));
    nand_cmos u_a2 (.a_i(na),     .b_i(na),   .y_o(c[i+1]));

    // Next state: inner mux picks increment vs hold, outer mux lets a load
    // override it. Reset is applied at the flop's D gate.
    mux2_cmos u_men (.s_i(bus.en), .a_i(sum[i]),   .b_i(o_q[i]),   .y_o(cnt_d[i]));
    mux2_cmos u_mst (.s_i(bus.st), .a_i(bus.x[i]), .b_i(cnt_d[i]), .y_o(o_d[i]));

    dff_cmos u_ff (.clk_i(clk), .rst_ni(rst_n), .d_i(o_d[i]), .q_o(o_q[i]));
  end

  // wrap_d = carry_out & en & ~st; a load edge always clears the flag.
  nand_cmos u_stn (.a_i(bus.st),   .b_i(bus.st), .y_o(st_n));
  nand_cmos u_ge0 (.a_i(bus.en),   .b_i(st_n),   .y_o(g_en));
  nand_cmos u_ge1 (.a_i(g_en),     .b_i(g_en),   .y_o(en_cnt));
  nand_cmos u_gw0 (.a_i(c[WIDTH]), .b_i(en_cnt), .y_o(g_wr));
  nand_cmos u_gw1 (.a_i(g_wr),     .b_i(g_wr),   .y_o(wrap_d));

  dff_cmos u_ff_wrap (.clk_i(clk), .rst_ni(rst_n), .d_i(wrap_d), .q_o(wrap_q));

  assign bus.o    = o_q;
  assign bus.wrap = wrap_q;
endmodule

// File: doc/counter16_cmos.md
Name: counter16_cmos

Overview:
- Program-counter-style register stage that sits directly downstream of the CMOS NAND gate layer.
- Built from NAND-derived logic: a WIDTH-bit registered counter with a synchronous load and a count enable.
- Produces a one-cycle wrap flag so the counter can chain into higher-level sequencing (timers, PC, RAM address stepping).
- This is the first clocked element in the optional CMOS track; it consumes the combinational gate primitives and turns them into state.

Parameters:
- WIDTH, 16, number of counter bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- st  input  1  store; when high, load x into the counter.
- x  input  WIDTH  load value.
- en  input  1  count enable; increment when high and st is low.
- o  output  WIDTH  current counter value (registered).
- wrap  output  1  one-cycle pulse: the increment on this edge rolled over from all-ones to zero.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. There is no asynchronous reset path; rst_n changing between edges has no effect until the next rising edge.
- All outputs are registered. There is no combinational path from st, x or en to o or wrap.
- Priority on each rising edge of clk, highest first:
  1. rst_n == 0: o <= 0, wrap <= 0.
  2. st == 1: o <= x, wrap <= 0. The en value is ignored this cycle.
  3. en == 1: o <= (o + 1) mod 2^WIDTH; wrap <= 1 iff o was all-ones before the edge, else 0.
  4. Otherwise: o holds, wrap <= 0.
- Latency: a load or increment is visible on o one cycle after the sampling edge. wrap is asserted in the same cycle in which o first shows 0 after rollover.
- wrap is never high for two consecutive cycles unless WIDTH ones-to-zero rollovers occur back-to-back. That requires a load of all-ones on the cycle between them, and that load forces wrap=0 on its own edge; so wrap is strictly single-cycle.
- Boundary cases:
  - Load of all-ones followed by en=1: next edge gives o=0, wrap=1.
  - st=1 with x = current o: o unchanged, wrap=0.
  - st and en both high: load wins, no increment.
  - Reset mid-count (rst_n low for one edge): o=0, wrap=0 on that edge. Counting resumes from 1 on the first enabled edge after rst_n returns high.
  - Before the first reset edge, o and wrap are X. The bench must not check them until after reset.
- Arithmetic:
  - The increment is a ripple half-adder chain: carry-in 1 at bit 0, carry-out of bit WIDTH-1 drives wrap.
  - The XOR/AND of each half adder is composed from NAND_CMOS instances (4 NANDs per XOR, 2 per AND).
  - The next-state mux (reset/st/en/hold) is also built from NAND-level logic.
  - Behavioural "+" is forbidden in the datapath; it is permitted only in the testbench model.

Decomposition:
- Shared include (guarded): counter width default, and reset/load encoding constants (RST_ACTIVE = 1'b0).
- Sub-module dff_cmos:
  - 1-bit rising-edge D flip-flop with synchronous active-low reset.
  - Built from NAND_CMOS master/slave latches plus a reset gate on D.
  - Instantiated WIDTH+1 times: WIDTH for o, 1 for wrap.
- Half-adder cells are instantiated inline via a generate loop, not a separate module.
- Testbench guarded by its own TB_ define, matching the existing optional-level benches.

Test Plan:
- Reset: rst_n=0 for 2 edges with st=1, x=16'h1234, en=1 -> o=16'h0000, wrap=0 (reset beats load).
- Count: after reset, en=1 for 5 edges -> o steps 1,2,3,4,5; wrap=0 throughout; en=0 for 3 edges -> o holds 5.
- Load priority: st=1, en=1, x=16'hABCD -> o=16'hABCD next cycle; then st=0, en=1 -> o=16'hABCE.
- Wrap: load x=16'hFFFF, then en=1 -> o=16'h0000, wrap=1 for exactly one cycle; next edge o=16'h0001, wrap=0.
- Reset mid-operation: counting at o=16'h0040, drop rst_n for one edge -> o=0, wrap=0; raise rst_n with en=1 -> o=1.
- Random: 1000 cycles of random st/en/x/rst_n against a behavioural reference model -> o and wrap match every cycle after the first reset.
